// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the 1x3 router packet source: header field widths,
// payload limits, the illegal destination code and the transmitter state set.
package router_pkt_tx_pkg;

    localparam int HDR_ADDR_W  = 2;
    localparam int HDR_LEN_W   = 6;
    localparam int MAX_PAYLOAD = 63;
    localparam logic [HDR_ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [HDR_LEN_W-1:0]  len,
                                               input logic [HDR_ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

    function automatic logic req_legal(input logic [HDR_ADDR_W-1:0] addr,
                                       input logic [HDR_LEN_W-1:0]  len);
        return (addr != ADDR_ILLEGAL) && (len != '0);
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for router_pkt_tx: 64x8 register file, one write port and one
// combinational read port addressed by the caller's registered indices.
module router_tx_buf
    import router_pkt_tx_pkg::*;
(
    input  logic                 clock,
    input  logic                 we,
    input  logic [HDR_LEN_W-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [HDR_LEN_W-1:0] raddr,
    output logic [7:0]           rdata
);

    // Storage is deliberately not reset; contents are only read after being written.
    logic [7:0] mem [0:MAX_PAYLOAD];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header, payload
// and parity bytes. Optional feature macro: ROUTER_TX_PARITY_INJ_EN (parity error injection).
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int unsigned IPG = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [HDR_ADDR_W-1:0] dest_addr,
    input  logic [HDR_LEN_W-1:0]  pay_len,
    output logic                  tx_ready,
    output logic                  req_reject,
    input  logic [7:0]            pay_data,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    input  logic                  busy,
    output logic [7:0]            data_out,
    output logic                  pkt_valid,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic                  inj_parity_err,
`endif
    output logic                  pkt_done
);

    tx_state_e            state_q, state_d;
    logic [7:0]           hdr_q, hdr_d;
    logic [7:0]           parity_q, parity_d;
    logic                 inj_q, inj_d;
    logic [HDR_LEN_W-1:0] wr_idx_q, wr_idx_d;
    logic [HDR_LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic [3:0]           gap_q, gap_d;
    logic [7:0]           data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 done_q, done_d;
    logic                 rej_q, rej_d;
    logic                 buf_we;
    logic [7:0]           buf_rdata;
    logic                 inj_req;

`ifdef ROUTER_TX_PARITY_INJ_EN
    assign inj_req = inj_parity_err;
`else
    assign inj_req = 1'b0;
`endif

    function automatic logic [7:0] parity_byte(input logic [7:0] p, input logic inj);
        return inj ? ~p : p;
    endfunction

    router_tx_buf u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (wr_idx_q),
        .wdata (pay_data),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            hdr_q    <= '0;
            parity_q <= '0;
            inj_q    <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            parity_q <= parity_d;
            inj_q    <= inj_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        parity_d = parity_q;
        inj_d    = inj_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        gap_d    = gap_q;
        data_d   = data_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        rej_d    = 1'b0;
        buf_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_legal(dest_addr, pay_len)) begin
                        hdr_d    = make_header(pay_len, dest_addr);
                        parity_d = make_header(pay_len, dest_addr);
                        inj_d    = inj_req;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = S_COLLECT;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            // Whole payload is buffered first so the router never sees a valid gap.
            S_COLLECT: begin
                if (pay_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ pay_data;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == hdr_q[7:2] - 1'b1) begin
                        data_d  = hdr_q;
                        vld_d   = 1'b1;
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    data_d   = buf_rdata;
                    rd_idx_d = rd_idx_q + 1'b1;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (rd_idx_q == hdr_q[7:2]) begin
                        data_d  = parity_byte(parity_q, inj_q);
                        vld_d   = 1'b0;
                        state_d = S_PARITY;
                    end else begin
                        data_d   = buf_rdata;
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    data_d  = '0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == 4'(IPG - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_ready   = (state_q == S_IDLE);
    assign pay_ready  = (state_q == S_COLLECT);
    assign data_out   = data_q;
    assign pkt_valid  = vld_q;
    assign pkt_done   = done_q;
    assign req_reject = rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte sequences, busy stalls, rejects,
// gappy payload input, asynchronous reset and (with the macro) parity injection.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = '0;
    logic [5:0] pay_len = '0;
    logic       tx_ready;
    logic       req_reject;
    logic [7:0] pay_data = '0;
    logic       pay_valid = 1'b0;
    logic       pay_ready;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       pkt_done;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       inj_parity_err = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] pay [64];
    logic [7:0] par;

    always #5 clock = ~clock;

    router_pkt_tx #(.IPG(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .dest_addr  (dest_addr),
        .pay_len    (pay_len),
        .tx_ready   (tx_ready),
        .req_reject (req_reject),
        .pay_data   (pay_data),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .busy       (busy),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
`ifdef ROUTER_TX_PARITY_INJ_EN
        .inj_parity_err (inj_parity_err),
`endif
        .pkt_done   (pkt_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input int hold_hdr,
                           input bit gappy, input bit inj, output logic [7:0] par_seen);
        logic [7:0] exp_par;
        logic [7:0] hdr;
        int i;
        int cyc;
        hdr = {len, addr};
        exp_par = hdr;
        chk("pre_tx_ready", {7'd0, tx_ready}, 8'd1);
        start = 1'b1; dest_addr = addr; pay_len = len;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_parity_err = inj;
`endif
        tick();
        start = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_parity_err = 1'b0;
`endif
        chk("collect_tx_ready", {7'd0, tx_ready}, 8'd0);
        chk("collect_pay_ready", {7'd0, pay_ready}, 8'd1);
        i = 0; cyc = 0;
        while (i < int'(len) && cyc < 1000) begin
            pay_valid = gappy ? (cyc % 2 == 0) : 1'b1;
            pay_data  = pay[i];
            if (cyc < 4) chk("collect_vld_low", {7'd0, pkt_valid}, 8'd0);
            tick();
            if (pay_valid) begin
                exp_par = exp_par ^ pay[i];
                i++;
            end
            cyc++;
        end
        pay_valid = 1'b0;
        if (i < int'(len)) chk("collect_timeout", 8'(i), 8'(len));
        if (inj) exp_par = ~exp_par;
        chk("hdr_byte", data_out, hdr);
        chk("hdr_vld", {7'd0, pkt_valid}, 8'd1);
        chk("hdr_pay_ready", {7'd0, pay_ready}, 8'd0);
        busy = (hold_hdr > 0);
        for (int h = 0; h < hold_hdr; h++) begin
            tick();
            chk("hdr_hold_byte", data_out, hdr);
            chk("hdr_hold_vld", {7'd0, pkt_valid}, 8'd1);
        end
        busy = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            tick();
            chk("pay_byte", data_out, pay[k]);
            chk("pay_vld", {7'd0, pkt_valid}, 8'd1);
        end
        tick();
        chk("parity_byte", data_out, exp_par);
        chk("parity_vld", {7'd0, pkt_valid}, 8'd0);
        par_seen = data_out;
        tick();
        chk("done_pulse", {7'd0, pkt_done}, 8'd1);
        chk("gap_data", data_out, 8'h00);
        chk("gap_tx_ready0", {7'd0, tx_ready}, 8'd0);
        tick();
        chk("done_low", {7'd0, pkt_done}, 8'd0);
        chk("gap_tx_ready1", {7'd0, tx_ready}, 8'd0);
        tick();
        chk("idle_tx_ready", {7'd0, tx_ready}, 8'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_data", data_out, 8'h00);
        chk("rst_vld", {7'd0, pkt_valid}, 8'd0);
        chk("rst_pay_ready", {7'd0, pay_ready}, 8'd0);
        chk("rst_done", {7'd0, pkt_done}, 8'd0);
        chk("rst_rej", {7'd0, req_reject}, 8'd0);
        chk("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
        resetn = 1'b1;
        tick();

        // Basic packet: addr 1, len 3
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 0, 1'b0, 1'b0, par);
        chk("t1_parity_const", par, 8'h0D);

        // Same packet, header stalled 4 cycles
        run_pkt(2'd1, 6'd3, 4, 1'b0, 1'b0, par);
        chk("t2_parity_const", par, 8'h0D);

        // Illegal requests
        start = 1'b1; dest_addr = 2'd3; pay_len = 6'd5;
        tick();
        start = 1'b0;
        chk("rej_addr_pulse", {7'd0, req_reject}, 8'd1);
        chk("rej_addr_tx_ready", {7'd0, tx_ready}, 8'd1);
        chk("rej_addr_pay_ready", {7'd0, pay_ready}, 8'd0);
        tick();
        chk("rej_addr_pulse_end", {7'd0, req_reject}, 8'd0);
        chk("rej_addr_vld", {7'd0, pkt_valid}, 8'd0);
        start = 1'b1; dest_addr = 2'd0; pay_len = 6'd0;
        tick();
        start = 1'b0;
        chk("rej_len_pulse", {7'd0, req_reject}, 8'd1);
        chk("rej_len_pay_ready", {7'd0, pay_ready}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rej_len_quiet_rej", {7'd0, req_reject}, 8'd0);
            chk("rej_len_quiet_vld", {7'd0, pkt_valid}, 8'd0);
            chk("rej_len_quiet_pr", {7'd0, pay_ready}, 8'd0);
        end

        // Max-length packet with 50% payload gaps
        for (int k = 0; k < 64; k++) pay[k] = 8'(k * 37 + 5);
        run_pkt(2'd2, 6'd63, 0, 1'b1, 1'b0, par);

        // Reset during payload byte 5
        for (int k = 0; k < 8; k++) pay[k] = 8'(8'hA0 + k);
        start = 1'b1; dest_addr = 2'd0; pay_len = 6'd8;
        tick();
        start = 1'b0;
        pay_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pay_data = pay[k];
            tick();
        end
        pay_valid = 1'b0;
        chk("rstmid_hdr", data_out, 8'h20);
        for (int k = 0; k < 5; k++) tick();
        chk("rstmid_byte5", data_out, pay[4]);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_data", data_out, 8'h00);
        chk("rstmid_vld", {7'd0, pkt_valid}, 8'd0);
        chk("rstmid_tx_ready", {7'd0, tx_ready}, 8'd1);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_tx_ready", {7'd0, tx_ready}, 8'd1);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 0, 1'b0, 1'b0, par);
        chk("post_rst_parity", par, 8'h0D);

`ifdef ROUTER_TX_PARITY_INJ_EN
        run_pkt(2'd1, 6'd3, 0, 1'b0, 1'b1, par);
        chk("inj_parity", par, 8'hF2);
        run_pkt(2'd1, 6'd3, 0, 1'b0, 1'b0, par);
        chk("inj_next_parity", par, 8'h0D);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router: accepts a packet request (destination, length) plus a payload byte stream, buffers the payload, and drives the router input port with header, payload and parity bytes. Drives `pkt_valid` and `data_in`, honours router `busy`, and computes the trailing parity byte that the router's register stage checks. Used as the traffic generator in system benches and as the upstream port adapter in integration.

## Interface
- `IPG`, 2, idle cycles inserted after each parity byte before `tx_ready` returns (legal range 1..15).
- `clock`  in  1  single clock, all logic rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled only while `tx_ready`=1.
- `dest_addr`  in  2  destination port 0..2, sampled with `start`.
- `pay_len`  in  6  payload byte count 1..63, sampled with `start`.
- `tx_ready`  out  1  high only in IDLE.
- `req_reject`  out  1  one-cycle pulse: illegal request dropped.
- `pay_data`  in  8  payload byte.
- `pay_valid`  in  1  payload byte present.
- `pay_ready`  out  1  payload byte accepted when `pay_valid`&`pay_ready`.
- `busy`  in  1  router stall; a presented byte is consumed only on an edge with `busy`=0.
- `data_out`  out  8  byte to router `data_in`.
- `pkt_valid`  out  1  high for header and payload bytes, low for parity byte.
- `pkt_done`  out  1  one-cycle pulse after parity byte consumed.

## Operation
- States: IDLE, COLLECT, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `start`=1 with `dest_addr`!=3 and `pay_len`!=0 -> latch request, parity <= header, go COLLECT. Illegal request -> `req_reject` pulse next cycle, stay IDLE. `start` outside IDLE ignored.
- Header byte = {`pay_len`, `dest_addr`}.
- COLLECT: `pay_ready`=1; each handshake writes buffer[wr_idx], parity ^= byte, wr_idx++. Final byte -> HEADER. `pay_valid` gaps simply extend COLLECT; the router never sees a gap.
- HEADER/PAYLOAD: byte presented on `data_out`, `pkt_valid`=1; on edge with `busy`=0, next byte loaded (buffer[rd_idx]). After last payload byte consumed -> PARITY.
- PARITY: `data_out`=parity, `pkt_valid`=0; consumed on `busy`=0 edge -> GAP, `pkt_done` pulse, `data_out` <= 0.
- GAP: count IPG cycles, then IDLE.
- Parity = XOR of header and all payload bytes, 8-bit.
- `pay_ready`=0 in all states except COLLECT.

## Timing
- Reset values: `data_out`=0, `pkt_valid`=0, `pay_ready`=0, `pkt_done`=0, `req_reject`=0, `tx_ready`=1 (state IDLE), counters and parity 0.
- `data_out`, `pkt_valid`, `pkt_done`, `req_reject` are registered. `tx_ready` and `pay_ready` decode directly from state.
- Header appears the cycle after the final payload handshake. With `busy`=0 throughout, bytes change every cycle: header, N payload, parity. That is N+2 cycles on the router port.
- `busy` high holds `data_out`/`pkt_valid` stable, with no limit.
- `pkt_done` is high the cycle after parity consumption. `tx_ready` rises IPG cycles after `pkt_done` rises.
- Reset mid-packet: outputs drop to reset values immediately. Buffer contents are don't-care. The truncated packet is the router's problem.

## Configuration
- `ROUTER_TX_PARITY_INJ_EN` defined: adds input `inj_parity_err` (1 bit), sampled with an accepted `start`. When set, the transmitted parity byte is ~parity for that packet only, used to exercise router `err`.
- `ROUTER_TX_PARITY_INJ_EN` undefined: the port does not exist and parity is always correct.

## Structure
- Shared router package: state enum, `HDR_ADDR_W`=2, `HDR_LEN_W`=6, `MAX_PAYLOAD`=63, illegal address constant 2'b11.
- Sub-module `router_tx_buf`: 64x8 register buffer, one write port and one read port with registered indices, no reset on storage.

## Test plan
- addr 1, len 3, payload 0x11,0x22,0x33, `busy`=0 -> port sequence 0x0D(v=1),0x11,0x22,0x33,parity 0x0D(v=0). `pkt_done` one cycle. `tx_ready` IPG cycles later.
- Same packet, `busy` high 4 cycles while header presented -> `data_out`=0x0D and `pkt_valid`=1 held 5 cycles, then the sequence resumes unchanged.
- `start` with addr 3 or len 0 -> `req_reject` pulse, no `pay_ready`, `pkt_valid` never rises.
- len 63, addr 2, `pay_valid` toggling 50% -> 65 contiguous port bytes, no `pkt_valid` gap, parity matches the model.
- `resetn` low during PAYLOAD byte 5 -> `pkt_valid`=0 and `data_out`=0 asynchronously; after release `tx_ready`=1 and the next packet is sent correctly.
- With `ROUTER_TX_PARITY_INJ_EN`, `inj_parity_err`=1 on the first packet -> parity 0xF2 for the first packet, and the following packet's parity is correct.
